// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - native CPU bus (mem_valid/mem_ready) for the product engine
interface mul_sequencer_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - memory-mapped chained product engine; MUL_SEQUENCER_OVF_EN adds 96-bit overflow detect
module mul_sequencer #(
    parameter logic [31:0] ADDR_BASE = 32'h0100_5000,
    parameter int          N         = 3
) (
    input  logic           clk,
    input  logic           resetn,
    mul_sequencer_if.slave bus,
    output logic           busy,
    output logic           done
);
    localparam int         IW    = (N > 1) ? $clog2(N) : 1;
    localparam int         DEPTH = 1 << IW;
    localparam logic [7:0] NMAX  = 8'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] result_q, result_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        push;

    // Power-of-two depth so every idx/count slice addresses a real entry
    logic [31:0] opnd_q [DEPTH];

    logic access, is_wr, mapped;
    logic sel_op, sel_ctrl, sel_stat, sel_rlo, sel_rhi;
    logic [31:0] cur_op;
    logic last_step, step_ovf;

    assign access   = bus.mem_valid && !ready_q;
    assign is_wr    = |bus.mem_wstrb;
    assign sel_op   = (bus.mem_addr == ADDR_BASE);
    assign sel_ctrl = (bus.mem_addr == ADDR_BASE + 32'h4);
    assign sel_stat = (bus.mem_addr == ADDR_BASE + 32'h8);
    assign sel_rlo  = (bus.mem_addr == ADDR_BASE + 32'hC);
    assign sel_rhi  = (bus.mem_addr == ADDR_BASE + 32'h10);
    assign mapped   = sel_op | sel_ctrl | sel_stat | sel_rlo | sel_rhi;

    assign cur_op    = opnd_q[idx_q[IW-1:0]];
    assign last_step = (idx_q == 8'(count_q - 8'd1));

`ifdef MUL_SEQUENCER_OVF_EN
    logic [95:0] prod;
    assign prod     = {32'b0, acc_q} * {64'b0, cur_op};
    assign step_ovf = |prod[95:64];
`else
    logic [63:0] prod;
    assign prod     = acc_q * {32'b0, cur_op};
    assign step_ovf = 1'b0;
`endif

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        idx_d    = idx_q;
        count_d  = count_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b0;
        rdata_d  = 32'h0;
        push     = 1'b0;

        if (state_q == S_RUN) begin
            if (count_q == 8'd0) begin
                result_d = 64'd1;
                state_d  = S_DONE;
            end else begin
                acc_d = prod[63:0];
                idx_d = idx_q + 8'd1;
                if (step_ovf) begin
                    ovf_d = 1'b1;
                end
                if (last_step) begin
                    result_d = prod[63:0];
                    state_d  = S_DONE;
                end
            end
        end

        // Bus effects applied after the run step so CLEAR overrides any step outcome
        if (access && mapped) begin
            ready_d = 1'b1;
            if (!is_wr) begin
                if (sel_stat) begin
                    rdata_d = {16'h0, count_q, 4'h0, err_q, ovf_q, done, busy};
                end else if (sel_rlo) begin
                    rdata_d = result_q[31:0];
                end else if (sel_rhi) begin
                    rdata_d = result_q[63:32];
                end
            end else if (sel_op) begin
                if (busy || count_q == NMAX) begin
                    err_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end else if (sel_ctrl) begin
                if (bus.mem_wdata[1]) begin
                    count_d = 8'd0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.mem_wdata[0]) begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        acc_d   = 64'd1;
                        idx_d   = 8'd0;
                        ovf_d   = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            acc_q    <= 64'd1;
            result_q <= 64'd0;
            idx_q    <= 8'd0;
            count_q  <= 8'd0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // Operand storage needs no reset: count gates which entries are live
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            opnd_q[count_q[IW-1:0]] <= bus.mem_wdata;
        end
    end
endmodule
